// File: rtl/ara_mon_pkg.sv
// Shared types and constants for the Ara runtime monitor.
// Optional feature macro: ARA_RUNTIME_MON_SATURATE_EN (see ara_mon_counter).
package ara_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } mon_state_e;

  localparam int DefaultCntWidth = 64;

  // Default meaning of the event strobe bits
  localparam int EvDcacheStall = 0;
  localparam int EvIcacheStall = 1;
  localparam int EvSbFull      = 2;

endpackage

// File: rtl/ara_mon_counter.sv
// Single monitor counter with enable, clear and sticky overflow.
// ARA_RUNTIME_MON_SATURATE_EN defined: hold at all-ones on overflow; undefined: wrap to zero.
module ara_mon_counter #(
  parameter int Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             overflow_o
);

  logic [Width-1:0] cnt_q;
  logic             overflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else if (en_i) begin
      if (&cnt_q) begin
        overflow_q <= 1'b1;
`ifdef ARA_RUNTIME_MON_SATURATE_EN
        cnt_q      <= cnt_q;
`else
        cnt_q      <= '0;
`endif
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ara_runtime_monitor.sv
// Vector-runtime and event monitor: FSM, pending tracking and snapshot registers.
// Counter overflow behaviour depends on ARA_RUNTIME_MON_SATURATE_EN.
module ara_runtime_monitor
  import ara_mon_pkg::*;
#(
  parameter int NrClusters = 1,
  parameter int NrEvents   = 3,
  parameter int CntWidth   = DefaultCntWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sw_en_i,
  input  logic                         acc_req_valid_i,
  input  logic [NrClusters-1:0]        cluster_idle_i,
  input  logic [NrEvents-1:0]          event_i,
  input  logic                         clear_i,
  output logic [CntWidth-1:0]          runtime_o,
  output logic [NrEvents*CntWidth-1:0] event_cnt_o,
  output logic                         snap_valid_o,
  output logic [NrEvents:0]            overflow_o,
  output logic [1:0]                   state_o
);

  mon_state_e                  state_q, state_d;
  logic                        pending_q, pending_d;
  logic                        snap;
  logic                        all_idle;
  logic                        count_en;
  logic [CntWidth-1:0]         cnt [NrEvents+1];
  logic [CntWidth-1:0]         runtime_q;
  logic [NrEvents*CntWidth-1:0] event_snap_q;
  logic                        snap_valid_q;

  assign all_idle = &cluster_idle_i;
  assign count_en = (state_q == RUN);

  // Counter 0 is the runtime, counter k+1 tracks event k
  for (genvar g = 0; g <= NrEvents; g++) begin : gen_cnt
    logic inc;
    if (g == 0) begin : gen_rt
      assign inc = count_en;
    end else begin : gen_ev
      assign inc = count_en & event_i[g-1];
    end
    ara_mon_counter #(
      .Width(CntWidth)
    ) i_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear_i),
      .en_i      (inc),
      .cnt_o     (cnt[g]),
      .overflow_o(overflow_o[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    snap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sw_en_i && acc_req_valid_i) begin
          state_d   = RUN;
          pending_d = 1'b1;
        end
      end
      RUN: begin
        snap = pending_q && all_idle && !acc_req_valid_i;
        if (snap) begin
          pending_d = 1'b0;
        end else if (acc_req_valid_i) begin
          pending_d = 1'b1;
        end
        if (!sw_en_i && all_idle && !pending_q) begin
          state_d = STOPPED;
        end
      end
      STOPPED: begin
        state_d = STOPPED;
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Snapshots take the counter values from the start of the cycle, before this cycle's increment
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      runtime_q    <= '0;
      event_snap_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      snap_valid_q <= snap;
      if (snap) begin
        runtime_q <= cnt[0];
        for (int k = 0; k < NrEvents; k++) begin
          event_snap_q[k*CntWidth +: CntWidth] <= cnt[k+1];
        end
      end
    end
  end

  assign runtime_o    = runtime_q;
  assign event_cnt_o  = event_snap_q;
  assign snap_valid_o = snap_valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ara_runtime_monitor.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_ara_runtime_monitor;

  localparam int NrClusters = 2;
  localparam int NrEvents   = 3;
  localparam int CntWidth   = 6;
  localparam longint MaxCnt = (64'd1 << CntWidth) - 1;

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b1;
  logic                         sw_en_i = 1'b0;
  logic                         acc_req_valid_i = 1'b0;
  logic [NrClusters-1:0]        cluster_idle_i = '1;
  logic [NrEvents-1:0]          event_i = '0;
  logic                         clear_i = 1'b0;
  logic [CntWidth-1:0]          runtime_o;
  logic [NrEvents*CntWidth-1:0] event_cnt_o;
  logic                         snap_valid_o;
  logic [NrEvents:0]            overflow_o;
  logic [1:0]                   state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: running/stopped flags, outstanding-request flag, plain integer counts
  bit     m_running, m_stopped, m_pending, m_snap_valid;
  longint m_count [NrEvents+1];
  longint m_snap  [NrEvents+1];
  bit     m_ovf   [NrEvents+1];

  ara_runtime_monitor #(
    .NrClusters(NrClusters),
    .NrEvents  (NrEvents),
    .CntWidth  (CntWidth)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sw_en_i        (sw_en_i),
    .acc_req_valid_i(acc_req_valid_i),
    .cluster_idle_i (cluster_idle_i),
    .event_i        (event_i),
    .clear_i        (clear_i),
    .runtime_o      (runtime_o),
    .event_cnt_o    (event_cnt_o),
    .snap_valid_o   (snap_valid_o),
    .overflow_o     (overflow_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_running = 0; m_stopped = 0; m_pending = 0; m_snap_valid = 0;
    for (int k = 0; k <= NrEvents; k++) begin
      m_count[k] = 0; m_snap[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic bump(input int k);
    if (m_count[k] == MaxCnt) begin
      m_ovf[k] = 1;
`ifdef ARA_RUNTIME_MON_SATURATE_EN
      m_count[k] = MaxCnt;
`else
      m_count[k] = 0;
`endif
    end else begin
      m_count[k] = m_count[k] + 1;
    end
  endtask

  task automatic modelStep();
    bit all_idle, take_snap, go_stop;
    if (rst_i || clear_i) begin
      modelReset();
      return;
    end
    all_idle = (cluster_idle_i == '1);
    m_snap_valid = 0;
    if (!m_running && !m_stopped) begin
      if (sw_en_i && acc_req_valid_i) begin
        m_running = 1;
        m_pending = 1;
      end
    end else if (m_running) begin
      take_snap = m_pending && all_idle && !acc_req_valid_i;
      go_stop   = !sw_en_i && all_idle && !m_pending;
      if (take_snap) begin
        for (int k = 0; k <= NrEvents; k++) m_snap[k] = m_count[k];
        m_snap_valid = 1;
        m_pending = 0;
      end else if (acc_req_valid_i) begin
        m_pending = 1;
      end
      bump(0);
      for (int k = 0; k < NrEvents; k++) if (event_i[k]) bump(k + 1);
      if (go_stop) begin
        m_running = 0;
        m_stopped = 1;
      end
    end
  endtask

  task automatic compareAll();
    logic [NrEvents*CntWidth-1:0] exp_ev;
    logic [NrEvents:0]            exp_ovf;
    logic [1:0]                   exp_state;
    for (int k = 0; k < NrEvents; k++) exp_ev[k*CntWidth +: CntWidth] = m_snap[k+1][CntWidth-1:0];
    for (int k = 0; k <= NrEvents; k++) exp_ovf[k] = m_ovf[k];
    exp_state = m_stopped ? 2'd2 : (m_running ? 2'd1 : 2'd0);
    checkOutput("state",     64'(state_o),      64'(exp_state));
    checkOutput("runtime",   64'(runtime_o),    64'(m_snap[0][CntWidth-1:0]));
    checkOutput("event_cnt", 64'(event_cnt_o),  64'(exp_ev));
    checkOutput("snap_vld",  64'(snap_valid_o), 64'(m_snap_valid));
    checkOutput("overflow",  64'(overflow_o),   64'(exp_ovf));
  endtask

  // One clock cycle: drive inputs, let the edge happen, step the model, compare
  task automatic applyStimulus(input logic en, input logic req, input logic [NrClusters-1:0] idle,
                               input logic [NrEvents-1:0] ev, input logic clr, input logic rst);
    @(negedge clk_i);
    sw_en_i = en; acc_req_valid_i = req; cluster_idle_i = idle;
    event_i = ev; clear_i = clr; rst_i = rst;
    @(posedge clk_i);
    modelStep();
    #1;
    compareAll();
  endtask

  initial begin
    modelReset();
    applyStimulus(0, 0, 2'b11, 3'b000, 0, 1);
    applyStimulus(0, 0, 2'b11, 3'b000, 0, 1);
    checkOutput("reset_state", 64'(state_o), 64'd0);

    // Basic runtime
    applyStimulus(1, 1, 2'b00, 3'b000, 0, 0);
    checkOutput("start_state", 64'(state_o), 64'd1);
    repeat (20) applyStimulus(1, 0, 2'b00, 3'b000, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
    checkOutput("basic_rt",   64'(runtime_o),    64'd20);
    checkOutput("basic_snap", 64'(snap_valid_o), 64'd1);
    checkOutput("basic_run",  64'(state_o),      64'd1);

    // Multi-cluster idle aggregation
    applyStimulus(1, 0, 2'b11, 3'b000, 1, 0);
    applyStimulus(1, 1, 2'b00, 3'b000, 0, 0);
    repeat (4) applyStimulus(1, 0, 2'b00, 3'b000, 0, 0);
    repeat (7) applyStimulus(1, 0, 2'b01, 3'b000, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
    checkOutput("multi_rt1", 64'(runtime_o), 64'd11);
    repeat (17) applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
    applyStimulus(1, 1, 2'b00, 3'b000, 0, 0);
    repeat (4) applyStimulus(1, 0, 2'b00, 3'b000, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
    checkOutput("multi_rt2", 64'(runtime_o), 64'd34);

    // Events only count while running
    applyStimulus(0, 0, 2'b11, 3'b000, 1, 0);
    repeat (3) applyStimulus(0, 0, 2'b11, 3'b010, 0, 0);
    applyStimulus(1, 1, 2'b00, 3'b010, 0, 0);
    repeat (5) applyStimulus(1, 0, 2'b00, 3'b001, 0, 0);
    repeat (3) applyStimulus(1, 0, 2'b00, 3'b000, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
    checkOutput("events", 64'(event_cnt_o), 64'd5);

    // Overflow after 68 counted cycles on a 6-bit counter
    applyStimulus(1, 0, 2'b11, 3'b000, 1, 0);
    applyStimulus(1, 1, 2'b00, 3'b000, 0, 0);
    repeat (68) applyStimulus(1, 0, 2'b00, 3'b000, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
`ifdef ARA_RUNTIME_MON_SATURATE_EN
    checkOutput("ovf_rt", 64'(runtime_o), 64'd63);
`else
    checkOutput("ovf_rt", 64'(runtime_o), 64'd4);
`endif
    checkOutput("ovf_bit0", 64'(overflow_o[0]), 64'd1);

    // Stop, ignore requests, then clear
    applyStimulus(0, 0, 2'b11, 3'b000, 0, 0);
    checkOutput("stopped", 64'(state_o), 64'd2);
    repeat (3) applyStimulus(1, 1, 2'b00, 3'b111, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b000, 0, 0);
    checkOutput("stop_hold", 64'(state_o), 64'd2);
    applyStimulus(0, 0, 2'b11, 3'b000, 1, 0);
    checkOutput("clear_state", 64'(state_o), 64'd0);
    checkOutput("clear_ovf",   64'(overflow_o), 64'd0);
    applyStimulus(1, 1, 2'b00, 3'b000, 1, 0);
    checkOutput("clear_req", 64'(state_o), 64'd0);

    // Reset in the middle of a run
    applyStimulus(1, 1, 2'b00, 3'b001, 0, 0);
    repeat (6) applyStimulus(1, 0, 2'b00, 3'b001, 0, 0);
    applyStimulus(1, 0, 2'b11, 3'b001, 0, 0);
    applyStimulus(1, 0, 2'b00, 3'b001, 0, 1);
    applyStimulus(1, 0, 2'b11, 3'b001, 0, 1);
    checkOutput("rst_state", 64'(state_o), 64'd0);
    checkOutput("rst_snap",  64'(snap_valid_o), 64'd0);
    checkOutput("rst_rt",    64'(runtime_o), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NrClusters-1:0] idle;
      for (int c = 0; c < NrClusters; c++) idle[c] = ($urandom % 3) != 0;
      applyStimulus(($urandom % 10) != 0, ($urandom % 6) == 0, idle,
                    NrEvents'($urandom), ($urandom % 150) == 0, ($urandom % 400) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
